uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter for the receiver-side test and loopback path. It serialises words from a small input FIFO onto the `rxd` line, using a configurable data width, parity mode, stop-bit count and bit period. Frames are sent back-to-back while the FIFO holds data. It replaces the fixed 8E1, one-clock-per-bit fast writer, and adds a valid/ready handshake, buffering and a real baud divider.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame, 5–9.
- `PARITY`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `CLKS_PER_BIT`, 1: clock cycles per bit, ≥1; 1 gives the fast mode.
- `FIFO_DEPTH`, 4: input FIFO entries, power of two, ≥2.

Ports:
- `clk`  in  1  the block's single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  `word` is presented for transmission.
- `word`  in  DATA_BITS  payload; bit 0 is sent first.
- `ready`  out  1  FIFO not full; a word is accepted on an edge where `valid && ready`.
- `rxd`  out  1  serial line; idles high.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- Frame order: start (0), `word[0]`…`word[DATA_BITS-1]`, parity bit if `PARITY`≠0, then `STOP_BITS` stop bits (1).
- Each bit is held for exactly `CLKS_PER_BIT` cycles.
- Frame length is F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Parity bit:
  - Even mode: XOR of the data bits, so the ones count over data plus parity is even.
  - Odd mode: the inverse of the even-mode bit.
- Parity is computed from the FIFO output word when that word is loaded into the shift register.
- FIFO:
  - Write on `valid && ready`.
  - Read when the FSM loads a new frame.
  - `ready = !full`, computed from the registered count only. A simultaneous pop does not admit a write into a full FIFO.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START: FIFO not empty. Pop the word into the shift register and drive `rxd` = 0.
  - START → DATA: after the bit period.
  - DATA: shift once per bit period. Leave after DATA_BITS periods, to PAR if `PARITY`≠0, otherwise to STOP.
  - PAR → STOP: after one bit period.
  - STOP, after STOP_BITS periods:
    - FIFO not empty: go to START and pop the next word in the same cycle. There is no idle gap between frames.
    - FIFO empty: go to IDLE.
- Counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit counter is sized to count DATA_BITS. Its width is `$clog2` of the maximum, and it never overflows.
- `rxd` is driven from a register; it never carries a combinational glitch.
- `word` may change freely after acceptance. Each frame uses the value latched at the FIFO write.
- Invalid parameter values (`PARITY`>2, `STOP_BITS`∉{1,2}, `CLKS_PER_BIT`=0) stop elaboration with `$error`.

## Timing
- Reset values: `rxd` = 1, `ready` = 1, `busy` = 0. FIFO empty, FSM in IDLE, counters zero.
- Latency: a word accepted at edge N with the FSM in IDLE and the FIFO empty drives `rxd` low from edge N+1. `busy` is 1 from edge N+1.
- Frame duration: F × CLKS_PER_BIT cycles, from the edge where `rxd` falls to the edge where the next frame starts or the line returns to idle.
- `busy` returns to 0 at the edge ending the last stop bit, when the FIFO is empty.
- Capacity: with the FSM busy, FIFO_DEPTH further words are accepted. The next write then sees `ready` = 0 until a pop, and `ready` rises the cycle after the pop edge.
- Reset mid-frame, at edge R:
  - `rxd` = 1 from R.
  - FIFO contents are discarded.
  - `ready` = 1 from R.
  - A `valid` sampled at R is ignored.
- `valid` while `ready` = 0: no write, no state change. The word is not held by the block.

## Test plan
- Fast 8E1 (defaults): write 0xA5 → `rxd` over 11 cycles = 0, 1,0,1,0,0,1,0,1, 0, 1. Start at edge N+1; `busy` low after cycle 11.
- Slow 8O1 (`PARITY`=2, `CLKS_PER_BIT`=4): write 0x01.
  - Required response: 4 cycles of 0, then 4 of 1, then 28 of 0.
  - Then parity 0 held 4 cycles, then stop 1 held 4 cycles; total 44 cycles.
- 7N2 (`DATA_BITS`=7, `PARITY`=0, `STOP_BITS`=2): write 0x7F.
  - Required response: 0, then seven 1s, then two stop 1s; 10 cycles.
  - A second word queued gives its start bit exactly on cycle 11.
- FIFO full (defaults, depth 4): hold `valid` high with 0x10..0x16.
  - The first word starts at once, 0x11–0x14 are queued, and `ready` drops.
  - 0x15 is accepted only after the first pop.
  - Decoded output is 0x10,0x11,0x12,0x13,0x14,0x15,… with no idle bits between frames.
- Reset mid-frame: assert `reset` for 1 cycle during the DATA bits of the first of 3 queued frames.
  - `rxd` = 1 and `ready` = 1 from that edge, and `busy` = 0.
  - No further frames are emitted.
  - A new write of 0x3C then transmits correctly.
- Invalid-parameter and stall check: elaborate with `PARITY`=3 → `$error`. Drive `valid` with `ready` = 0 → no FIFO count change.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: a small input FIFO feeds a frame FSM that
// serialises start, data (LSB first), optional parity and stop bits onto rxd.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] word,
  output logic                 ready,
  output logic                 rxd,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic              ODD_PAR   = (PARITY == 2);

  // Reject parameter combinations the datapath cannot represent.
  generate
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
      $error("uart_tx_param: CLKS_PER_BIT must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] fifo_head;

  // ready looks only at the registered count, so a same-cycle pop never
  // lets a write into a full FIFO.
  assign ready     = (count_q != FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = valid && ready;
  assign fifo_head = fifo_mem[rd_ptr_q];

  // Storage write; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= word;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 rxd_q, rxd_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign rxd     = rxd_q;
  assign busy    = (state_q != IDLE) || !empty;

  // State, counters, shifter and the line register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      rxd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rxd_q   <= rxd_d;
    end
  end

  // Next-state logic; rxd_d is the value the line carries from the next edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    rxd_d   = rxd_q;
    pop     = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        rxd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          par_d   = (^fifo_head) ^ ODD_PAR;
          rxd_d   = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          rxd_d   = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              rxd_d   = par_q;
              state_d = PAR;
            end else begin
              rxd_d   = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            rxd_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          rxd_d   = 1'b1;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!empty) begin
              // Back-to-back: load the next word with no idle gap.
              pop     = 1'b1;
              shift_d = fifo_head;
              par_d   = (^fifo_head) ^ ODD_PAR;
              rxd_d   = 1'b0;
              state_d = START;
            end else begin
              rxd_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        rxd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three parameterisations share clk/reset.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx_param;

  logic clk;
  logic reset;

  // defaults: 8E1, fast
  logic       d_valid, d_ready, d_rxd, d_busy;
  logic [7:0] d_word;
  // 8O1, 4 clocks per bit
  logic       s_valid, s_ready, s_rxd, s_busy;
  logic [7:0] s_word;
  // 7N2, fast
  logic       t_valid, t_ready, t_rxd, t_busy;
  logic [6:0] t_word;

  int checks   = 0;
  int failures = 0;

  uart_tx_param u_def (
    .clk(clk), .reset(reset), .valid(d_valid), .word(d_word),
    .ready(d_ready), .rxd(d_rxd), .busy(d_busy)
  );

  uart_tx_param #(.PARITY(2), .CLKS_PER_BIT(4)) u_slow (
    .clk(clk), .reset(reset), .valid(s_valid), .word(s_word),
    .ready(s_ready), .rxd(s_rxd), .busy(s_busy)
  );

  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .valid(t_valid), .word(t_word),
    .ready(t_ready), .rxd(t_rxd), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    d_valid = 1'b0; s_valid = 1'b0; t_valid = 1'b0;
    d_word = '0; s_word = '0; t_word = '0;
    @(negedge clk);
    @(negedge clk);
    checks += 9;
    if (d_rxd !== 1'b1)   begin failures++; $display("FAIL reset_def_rxd got=%b exp=1", d_rxd); end
    if (d_ready !== 1'b1) begin failures++; $display("FAIL reset_def_ready got=%b exp=1", d_ready); end
    if (d_busy !== 1'b0)  begin failures++; $display("FAIL reset_def_busy got=%b exp=0", d_busy); end
    if (s_rxd !== 1'b1)   begin failures++; $display("FAIL reset_slow_rxd got=%b exp=1", s_rxd); end
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_slow_ready got=%b exp=1", s_ready); end
    if (s_busy !== 1'b0)  begin failures++; $display("FAIL reset_slow_busy got=%b exp=0", s_busy); end
    if (t_rxd !== 1'b1)   begin failures++; $display("FAIL reset_7n2_rxd got=%b exp=1", t_rxd); end
    if (t_ready !== 1'b1) begin failures++; $display("FAIL reset_7n2_ready got=%b exp=1", t_ready); end
    if (t_busy !== 1'b0)  begin failures++; $display("FAIL reset_7n2_busy got=%b exp=0", t_busy); end
    $display("reset: rxd=%b/%b/%b ready=%b/%b/%b busy=%b/%b/%b",
             d_rxd, s_rxd, t_rxd, d_ready, s_ready, t_ready, d_busy, s_busy, t_busy);
    reset = 1'b0;
  endtask

  task automatic test_fast_8e1();
    logic [10:0] got;
    logic [10:0] exp_frame = 11'b10101001010; // 0xA5 even parity, bit0 = start
    @(negedge clk);
    d_valid = 1'b1; d_word = 8'hA5;
    @(negedge clk);                            // after acceptance edge N
    d_valid = 1'b0; d_word = 8'h00;
    checks++;
    if (d_rxd !== 1'b1) begin failures++; $display("FAIL fast_latency_early got=%b exp=1", d_rxd); end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      got[i] = d_rxd;
      if (i == 0) begin
        checks++;
        if (d_busy !== 1'b1) begin failures++; $display("FAIL fast_busy_start got=%b exp=1", d_busy); end
      end
    end
    checks++;
    if (got !== exp_frame) begin failures++; $display("FAIL fast_frame got=%b exp=%b", got, exp_frame); end
    @(negedge clk);
    checks += 2;
    if (d_busy !== 1'b0) begin failures++; $display("FAIL fast_busy_end got=%b exp=0", d_busy); end
    if (d_rxd !== 1'b1)  begin failures++; $display("FAIL fast_idle_rxd got=%b exp=1", d_rxd); end
    $display("fast_8e1: word=a5 frame=%b busy_after=%b", got, d_busy);
  endtask

  task automatic test_slow_8o1();
    logic [43:0] got;
    logic [43:0] exp_line;
    logic [10:0] bits = 11'b10000000010;       // 0x01 odd parity -> parity 0
    for (int i = 0; i < 44; i++) exp_line[i] = bits[i/4];
    @(negedge clk);
    s_valid = 1'b1; s_word = 8'h01;
    @(negedge clk);
    s_valid = 1'b0; s_word = 8'h00;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      got[i] = s_rxd;
    end
    checks++;
    if (got !== exp_line) begin failures++; $display("FAIL slow_line got=%h exp=%h", got, exp_line); end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("FAIL slow_busy_end got=%b exp=0", s_busy); end
    $display("slow_8o1: word=01 line=%h busy_after=%b", got, s_busy);
  endtask

  task automatic test_back_to_back_7n2();
    logic [19:0] got;
    @(negedge clk);
    t_valid = 1'b1; t_word = 7'h7F;
    @(negedge clk);
    t_word = 7'h2A;
    @(negedge clk);                            // after edge N+1
    t_valid = 1'b0; t_word = 7'h00;
    got[0] = t_rxd;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      got[i] = t_rxd;
    end
    checks += 3;
    if (got[9:0] !== 10'b1111111110)
      begin failures++; $display("FAIL 7n2_frame1 got=%b exp=%b", got[9:0], 10'b1111111110); end
    if (got[10] !== 1'b0)
      begin failures++; $display("FAIL 7n2_start_cycle11 got=%b exp=0", got[10]); end
    if (got[19:10] !== 10'b1101010100)
      begin failures++; $display("FAIL 7n2_frame2 got=%b exp=%b", got[19:10], 10'b1101010100); end
    @(negedge clk);
    checks++;
    if (t_busy !== 1'b0) begin failures++; $display("FAIL 7n2_busy_end got=%b exp=0", t_busy); end
    $display("back_to_back_7n2: frames=%b %b", got[9:0], got[19:10]);
  endtask

  task automatic test_fifo_full();
    int   acc [7];
    int   exp_acc [7] = '{0, 1, 2, 3, 4, 13, 24};
    logic cap [77];
    int   idx = 0;
    logic rdy5 = 1'b1;
    logic [7:0]  w;
    logic [10:0] obs, expf;
    @(negedge clk);
    for (int k = 0; k <= 77; k++) begin
      if (idx < 7) begin
        d_valid = 1'b1; d_word = 8'(8'h10 + idx);
        if (k == 5) rdy5 = d_ready;
        if (d_ready) begin acc[idx] = k; idx++; end
      end else begin
        d_valid = 1'b0;
      end
      @(negedge clk);
      if (k >= 1) cap[k-1] = d_rxd;
    end
    d_valid = 1'b0;
    checks++;
    if (rdy5 !== 1'b0) begin failures++; $display("FAIL full_ready_drop got=%b exp=0", rdy5); end
    checks++;
    if (idx != 7) begin failures++; $display("FAIL full_accept_count got=%0d exp=7", idx); end
    for (int i = 0; i < 7; i++) begin
      if (i < idx) begin
        checks++;
        if (acc[i] != exp_acc[i])
          begin failures++; $display("FAIL full_accept_cycle word%0d got=%0d exp=%0d", i, acc[i], exp_acc[i]); end
      end
    end
    for (int f = 0; f < 7; f++) begin
      w = 8'(8'h10 + f);
      expf = {1'b1, ^w, w, 1'b0};
      for (int b = 0; b < 11; b++) obs[b] = cap[f*11 + b];
      checks++;
      if (obs !== expf) begin failures++; $display("FAIL full_frame%0d got=%b exp=%b", f, obs, expf); end
      $display("fifo_full: frame%0d word=%h line=%b", f, w, obs);
    end
    @(negedge clk);
    checks++;
    if (d_busy !== 1'b0) begin failures++; $display("FAIL full_busy_end got=%b exp=0", d_busy); end
  endtask

  task automatic test_stall();
    logic cap [55];
    int   nacc = 0;
    int   rdy_hi = 0;
    logic [7:0]  w;
    logic [10:0] obs, expf;
    @(negedge clk);
    for (int k = 0; k <= 55; k++) begin
      if (k < 5) begin
        d_valid = 1'b1; d_word = 8'(8'h40 + k);
        if (d_ready) nacc++;
      end else if (k < 9) begin
        d_valid = 1'b1; d_word = 8'hEE;
        if (d_ready) rdy_hi++;
      end else begin
        d_valid = 1'b0;
      end
      @(negedge clk);
      if (k >= 1) cap[k-1] = d_rxd;
    end
    checks += 2;
    if (nacc != 5)   begin failures++; $display("FAIL stall_accepts got=%0d exp=5", nacc); end
    if (rdy_hi != 0) begin failures++; $display("FAIL stall_ready_high got=%0d exp=0", rdy_hi); end
    for (int f = 0; f < 5; f++) begin
      w = 8'(8'h40 + f);
      expf = {1'b1, ^w, w, 1'b0};
      for (int b = 0; b < 11; b++) obs[b] = cap[f*11 + b];
      checks++;
      if (obs !== expf) begin failures++; $display("FAIL stall_frame%0d got=%b exp=%b", f, obs, expf); end
    end
    @(negedge clk);
    checks += 2;
    if (d_busy !== 1'b0) begin failures++; $display("FAIL stall_busy_end got=%b exp=0", d_busy); end
    if (d_rxd !== 1'b1)  begin failures++; $display("FAIL stall_idle_rxd got=%b exp=1", d_rxd); end
    $display("stall: accepted=%0d ready_high_during_stall=%0d busy_after=%b", nacc, rdy_hi, d_busy);
  endtask

  task automatic test_reset_mid_frame();
    int   zeros = 0;
    int   busy_hi = 0;
    logic [10:0] got;
    logic [10:0] exp_frame = 11'b10001111000; // 0x3C even parity
    @(negedge clk);
    d_valid = 1'b1; d_word = 8'h11;
    @(negedge clk);
    d_word = 8'h22;
    @(negedge clk);
    d_word = 8'h33;
    @(negedge clk);                            // FSM now sending data bits
    reset = 1'b1; d_valid = 1'b1; d_word = 8'h55;
    @(negedge clk);                            // after reset edge R
    reset = 1'b0; d_valid = 1'b0; d_word = 8'h00;
    checks += 3;
    if (d_rxd !== 1'b1)   begin failures++; $display("FAIL midrst_rxd got=%b exp=1", d_rxd); end
    if (d_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", d_ready); end
    if (d_busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", d_busy); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (d_rxd !== 1'b1) zeros++;
      if (d_busy !== 1'b0) busy_hi++;
    end
    checks += 2;
    if (zeros != 0)   begin failures++; $display("FAIL midrst_no_frames got=%0d exp=0", zeros); end
    if (busy_hi != 0) begin failures++; $display("FAIL midrst_busy_idle got=%0d exp=0", busy_hi); end
    d_valid = 1'b1; d_word = 8'h3C;
    @(negedge clk);
    d_valid = 1'b0; d_word = 8'h00;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      got[i] = d_rxd;
    end
    checks++;
    if (got !== exp_frame) begin failures++; $display("FAIL midrst_new_frame got=%b exp=%b", got, exp_frame); end
    @(negedge clk);
    checks++;
    if (d_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy_end got=%b exp=0", d_busy); end
    $display("reset_mid_frame: stray_zeros=%0d new_frame=%b", zeros, got);
  endtask

  initial begin
    test_reset();
    test_fast_8e1();
    test_slow_8o1();
    test_back_to_back_7n2();
    test_fifo_full();
    test_stall();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
